// File: rtl/jedro_1_load_wb_if.sv
// Request/writeback bundle between the LSU/RAM side and the load writeback stage.
// master drives requests and RAM data; slave (the stage) drives the register-file port.
interface jedro_1_load_wb_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      req_valid_i;
    logic [3:0]                req_ctrl_i;
    logic [DATA_WIDTH-1:0]     req_addr_i;
    logic [REG_ADDR_WIDTH-1:0] req_regdest_i;
    logic                      flush_i;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;
    logic [DATA_WIDTH-1:0]     rf_wdata_o;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
    logic                      rf_we_o;
    logic                      misaligned_o;
    logic [DATA_WIDTH-1:0]     misaligned_addr_o;
    logic                      busy_o;

    modport master (
        output req_valid_i, req_ctrl_i, req_addr_i, req_regdest_i, flush_i, mem_rdata_i,
        input  rf_wdata_o, rf_waddr_o, rf_we_o, misaligned_o, misaligned_addr_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_ctrl_i, req_addr_i, req_regdest_i, flush_i, mem_rdata_i,
        output rf_wdata_o, rf_waddr_o, rf_we_o, misaligned_o, misaligned_addr_o, busy_o
    );
endinterface

// File: rtl/jedro_1_load_wb.sv
// Load writeback: 2-stage metadata pipe tracking RAM latency, extract/extend, RF write 3 cycles after request.
// No backpressure: one request accepted per cycle; misaligned/store/illegal requests never enter the pipe.
module jedro_1_load_wb #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    jedro_1_load_wb_if.slave   bus
);
    typedef struct packed {
        logic                      valid;
        logic                      is_load;
        logic [2:0]                funct3;
        logic [1:0]                addr;
        logic [REG_ADDR_WIDTH-1:0] regdest;
    } meta_t;

    meta_t s1, s2, s1_nxt;

    logic [2:0]                req_f3;
    logic                      req_legal;
    logic                      req_misaligned;
    logic                      req_enter;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;
    logic [DATA_WIDTH-1:0]     ext_data;
    logic                      wb_fire;

    logic [DATA_WIDTH-1:0]     rf_wdata_q;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q;
    logic                      rf_we_q;
    logic                      misaligned_q;
    logic [DATA_WIDTH-1:0]     misaligned_addr_q;

    assign req_f3    = bus.req_ctrl_i[2:0];
    assign req_legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010) ||
                       (req_f3 == 3'b100) || (req_f3 == 3'b101);

    // Alignment check covers stores too, so it ignores the write bit.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_f3)
            3'b001, 3'b101: req_misaligned = bus.req_addr_i[0];
            3'b010:         req_misaligned = |bus.req_addr_i[1:0];
            default:        req_misaligned = 1'b0;
        endcase
    end

    assign req_enter = bus.req_valid_i && !bus.req_ctrl_i[3] && req_legal &&
                       !req_misaligned && !bus.flush_i;

    always_comb begin
        s1_nxt         = '0;
        s1_nxt.valid   = req_enter;
        s1_nxt.is_load = !bus.req_ctrl_i[3];
        s1_nxt.funct3  = req_f3;
        s1_nxt.addr    = bus.req_addr_i[1:0];
        s1_nxt.regdest = bus.req_regdest_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= s1_nxt;
            s2 <= s1;
            if (bus.flush_i) begin
                s2.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        byte_sel = bus.mem_rdata_i[7:0];
        case (s2.addr)
            2'd0: byte_sel = bus.mem_rdata_i[7:0];
            2'd1: byte_sel = bus.mem_rdata_i[15:8];
            2'd2: byte_sel = bus.mem_rdata_i[23:16];
            2'd3: byte_sel = bus.mem_rdata_i[31:24];
            default: byte_sel = bus.mem_rdata_i[7:0];
        endcase
    end

    assign half_sel = s2.addr[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];

    always_comb begin
        ext_data = bus.mem_rdata_i;
        case (s2.funct3)
            3'b000:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: ext_data = bus.mem_rdata_i;
        endcase
    end

    assign wb_fire = s2.valid && s2.is_load && (s2.regdest != '0) && !bus.flush_i;

    // Data/address registers only move on a real write so they hold across idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_wdata_q        <= '0;
            rf_waddr_q        <= '0;
            rf_we_q           <= 1'b0;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= '0;
        end else begin
            rf_we_q      <= wb_fire;
            misaligned_q <= bus.req_valid_i && req_misaligned;
            if (wb_fire) begin
                rf_wdata_q <= ext_data;
                rf_waddr_q <= s2.regdest;
            end
            if (bus.req_valid_i && req_misaligned) begin
                misaligned_addr_q <= bus.req_addr_i;
            end
        end
    end

    assign bus.rf_wdata_o        = rf_wdata_q;
    assign bus.rf_waddr_o        = rf_waddr_q;
    assign bus.rf_we_o           = rf_we_q;
    assign bus.misaligned_o      = misaligned_q;
    assign bus.misaligned_addr_o = misaligned_addr_q;
    assign bus.busy_o            = s1.valid || s2.valid || rf_we_q;
endmodule

// File: tb/tb_jedro_1_load_wb.sv
// Bench for jedro_1_load_wb: directed scenarios plus a randomized run against a cycle-indexed model.
module tb_jedro_1_load_wb;
    localparam int NC = 300;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    jedro_1_load_wb_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    jedro_1_load_wb #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Randomized schedule, one entry per cycle.
    logic        rv [NC+4];
    logic [3:0]  rc [NC+4];
    logic [31:0] ra [NC+4];
    logic [4:0]  rr [NC+4];
    logic        fl [NC+4];
    logic [31:0] rw [NC+4];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid_i   = 1'b0;
        bus.req_ctrl_i    = 4'd0;
        bus.req_addr_i    = 32'd0;
        bus.req_regdest_i = 5'd0;
        bus.flush_i       = 1'b0;
        bus.mem_rdata_i   = $urandom;
    endtask

    task automatic drive_req(input logic [3:0] ctrl, input logic [31:0] addr, input logic [4:0] rd);
        bus.req_valid_i   = 1'b1;
        bus.req_ctrl_i    = ctrl;
        bus.req_addr_i    = addr;
        bus.req_regdest_i = rd;
    endtask

    // Leaves the bench in cycle N+3 of a single load, RAM word presented only in N+2.
    task automatic run_load(input logic [3:0] ctrl, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata);
        drive_req(ctrl, addr, rd);
        tick();
        drive_idle();
        tick();
        bus.mem_rdata_i = rdata;
        tick();
        bus.mem_rdata_i = $urandom;
    endtask

    function automatic logic legal_f3(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    function automatic logic is_mis(input logic [2:0] f, input logic [1:0] a);
        if (f == 3'd1 || f == 3'd5) return a[0];
        if (f == 3'd2) return a != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_extract(input logic [2:0] f, input logic [1:0] a,
                                                  input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic enters(input int n);
        return rv[n] && !rc[n][3] && legal_f3(rc[n][2:0]) && !is_mis(rc[n][2:0], ra[n][1:0]);
    endfunction

    task automatic test_reset();
        if (bus.rf_we_o !== 1'b0 || bus.rf_wdata_o !== 32'd0 || bus.rf_waddr_o !== 5'd0) begin
            $display("FAIL reset_rf: we=%b wdata=%h waddr=%0d required 0/0/0",
                     bus.rf_we_o, bus.rf_wdata_o, bus.rf_waddr_o);
            n_fail++;
        end
        n_tests++;
        if (bus.misaligned_o !== 1'b0 || bus.misaligned_addr_o !== 32'd0 || bus.busy_o !== 1'b0) begin
            $display("FAIL reset_misc: mis=%b mis_addr=%h busy=%b required 0/0/0",
                     bus.misaligned_o, bus.misaligned_addr_o, bus.busy_o);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_lw();
        run_load(4'b0010, 32'h100, 5'd5, 32'hDEAD_BEEF);
        if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd5 || bus.rf_wdata_o !== 32'hDEAD_BEEF) begin
            $display("FAIL lw: we=%b waddr=%0d wdata=%h required 1/5/deadbeef",
                     bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
            n_fail++;
        end
        n_tests++;
        tick();
        if (bus.rf_we_o !== 1'b0 || bus.rf_wdata_o !== 32'hDEAD_BEEF || bus.busy_o !== 1'b0) begin
            $display("FAIL lw_after: we=%b wdata=%h busy=%b required 0/deadbeef/0",
                     bus.rf_we_o, bus.rf_wdata_o, bus.busy_o);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_extend();
        logic [3:0]  ctl [7];
        logic [1:0]  adr [7];
        logic [31:0] exp [7];
        ctl = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0101};
        adr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
        exp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        for (int i = 0; i < 7; i++) begin
            run_load(ctl[i], {28'h000_0040, 2'b00, adr[i]}, 5'(i + 10), 32'h80FF_7F01);
            if (bus.rf_we_o !== 1'b1 || bus.rf_wdata_o !== exp[i] || bus.rf_waddr_o !== 5'(i + 10)) begin
                $display("FAIL extend_%0d: we=%b wdata=%h waddr=%0d required 1/%h/%0d",
                         i, bus.rf_we_o, bus.rf_wdata_o, bus.rf_waddr_o, exp[i], i + 10);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  ctl [2];
        logic [31:0] adr [2];
        ctl = '{4'b0010, 4'b1001};
        adr = '{32'h102, 32'h203};
        for (int i = 0; i < 2; i++) begin
            drive_req(ctl[i], adr[i], 5'd6);
            tick();
            drive_idle();
            if (bus.misaligned_o !== 1'b1 || bus.misaligned_addr_o !== adr[i] || bus.busy_o !== 1'b0) begin
                $display("FAIL mis_pulse_%0d: mis=%b addr=%h busy=%b required 1/%h/0",
                         i, bus.misaligned_o, bus.misaligned_addr_o, bus.busy_o, adr[i]);
                n_fail++;
            end
            n_tests++;
            tick();
            if (bus.misaligned_o !== 1'b0 || bus.misaligned_addr_o !== adr[i]) begin
                $display("FAIL mis_hold_%0d: mis=%b addr=%h required 0/%h",
                         i, bus.misaligned_o, bus.misaligned_addr_o, adr[i]);
                n_fail++;
            end
            n_tests++;
            tick();
            if (bus.rf_we_o !== 1'b0) begin
                $display("FAIL mis_nowb_%0d: we=%b required 0", i, bus.rf_we_o);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) drive_req(4'b0010, 32'(16 * k), 5'(k + 1));
            else       bus.req_valid_i = 1'b0;
            bus.mem_rdata_i = (k >= 2 && k < 6) ? d[k-2] : $urandom;
            if (k >= 3 && k < 7) begin
                if (bus.rf_we_o !== 1'b1 || bus.rf_wdata_o !== d[k-3] || bus.rf_waddr_o !== 5'(k - 2)) begin
                    $display("FAIL b2b_%0d: we=%b wdata=%h waddr=%0d required 1/%h/%0d",
                             k, bus.rf_we_o, bus.rf_wdata_o, bus.rf_waddr_o, d[k-3], k - 2);
                    n_fail++;
                end
            end else if (bus.rf_we_o !== 1'b0) begin
                $display("FAIL b2b_idle_%0d: we=%b required 0", k, bus.rf_we_o);
                n_fail++;
            end
            n_tests++;
            tick();
        end
        drive_idle();
    endtask

    task automatic test_rd0_flush();
        run_load(4'b0010, 32'h300, 5'd0, 32'h1111_2222);
        if (bus.rf_we_o !== 1'b0) begin
            $display("FAIL rd0: we=%b required 0", bus.rf_we_o);
            n_fail++;
        end
        n_tests++;
        tick();
        drive_req(4'b0010, 32'h304, 5'd7);
        tick();
        drive_idle();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.mem_rdata_i = 32'h5555_AAAA;
        if (bus.busy_o !== 1'b0) begin
            $display("FAIL flush_busy: busy=%b required 0", bus.busy_o);
            n_fail++;
        end
        n_tests++;
        tick();
        if (bus.rf_we_o !== 1'b0) begin
            $display("FAIL flush_nowb: we=%b required 0", bus.rf_we_o);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_reset_midload();
        drive_req(4'b0010, 32'h40, 5'd9);
        tick();
        drive_idle();
        rst_i = 1'b1;
        #1;
        if (bus.rf_we_o !== 1'b0 || bus.rf_wdata_o !== 32'd0 || bus.rf_waddr_o !== 5'd0 ||
            bus.misaligned_o !== 1'b0 || bus.misaligned_addr_o !== 32'd0 || bus.busy_o !== 1'b0) begin
            $display("FAIL reset_mid: we=%b wdata=%h waddr=%0d mis=%b mis_addr=%h busy=%b required all 0",
                     bus.rf_we_o, bus.rf_wdata_o, bus.rf_waddr_o, bus.misaligned_o,
                     bus.misaligned_addr_o, bus.busy_o);
            n_fail++;
        end
        n_tests++;
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.rf_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                $display("FAIL reset_post_%0d: we=%b busy=%b required 0/0", k, bus.rf_we_o, bus.busy_o);
                n_fail++;
            end
            n_tests++;
        end
        run_load(4'b0010, 32'h44, 5'd3, 32'h1234_5678);
        if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd3 || bus.rf_wdata_o !== 32'h1234_5678) begin
            $display("FAIL reset_resume: we=%b waddr=%0d wdata=%h required 1/3/12345678",
                     bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_random();
        logic        e_s1, e_s2, e_we, e_mis, e_busy;
        logic [31:0] e_wdata, e_misaddr;
        logic [4:0]  e_waddr;
        for (int n = 0; n < NC + 4; n++) begin
            rv[n] = (n < NC) && ($urandom_range(0, 9) < 7);
            rc[n] = {($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7))};
            ra[n] = $urandom;
            if ($urandom_range(0, 1) == 0) ra[n][1:0] = 2'b00;
            rr[n] = 5'($urandom_range(0, 31));
            fl[n] = (n < NC) && ($urandom_range(0, 19) == 0);
            rw[n] = $urandom;
        end
        rst_i = 1'b1;
        drive_idle();
        tick();
        tick();
        rst_i = 1'b0;
        e_wdata = 32'd0;
        e_waddr = 5'd0;
        e_misaddr = 32'd0;
        for (int c = 0; c < NC + 4; c++) begin
            bus.req_valid_i   = rv[c];
            bus.req_ctrl_i    = rc[c];
            bus.req_addr_i    = ra[c];
            bus.req_regdest_i = rr[c];
            bus.flush_i       = fl[c];
            bus.mem_rdata_i   = rw[c];
            e_mis = (c >= 1) && rv[c-1] && is_mis(rc[c-1][2:0], ra[c-1][1:0]);
            if (e_mis) e_misaddr = ra[c-1];
            e_s1 = (c >= 1) && enters(c-1) && !fl[c-1];
            e_s2 = (c >= 2) && enters(c-2) && !fl[c-2] && !fl[c-1];
            e_we = (c >= 3) && enters(c-3) && !fl[c-3] && !fl[c-2] && !fl[c-1] && (rr[c-3] != 5'd0);
            if (e_we) begin
                e_wdata = model_extract(rc[c-3][2:0], ra[c-3][1:0], rw[c-1]);
                e_waddr = rr[c-3];
            end
            e_busy = e_s1 || e_s2 || e_we;
            if (bus.rf_we_o !== e_we || bus.rf_wdata_o !== e_wdata || bus.rf_waddr_o !== e_waddr) begin
                $display("FAIL rand_wb c=%0d: we=%b wdata=%h waddr=%0d required %b/%h/%0d",
                         c, bus.rf_we_o, bus.rf_wdata_o, bus.rf_waddr_o, e_we, e_wdata, e_waddr);
                n_fail++;
            end
            n_tests++;
            if (bus.misaligned_o !== e_mis || bus.misaligned_addr_o !== e_misaddr || bus.busy_o !== e_busy) begin
                $display("FAIL rand_misc c=%0d: mis=%b mis_addr=%h busy=%b required %b/%h/%b",
                         c, bus.misaligned_o, bus.misaligned_addr_o, bus.busy_o, e_mis, e_misaddr, e_busy);
                n_fail++;
            end
            n_tests++;
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_i = 1'b1;
        tick();
        tick();
        test_reset();
        rst_i = 1'b0;
        tick();
        test_lw();
        test_extend();
        test_misaligned();
        test_back_to_back();
        test_rd0_flush();
        test_reset_midload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jedro_1_load_wb.md
# jedro_1_load_wb

Load writeback stage of the jedro-1 core, sitting directly downstream of the load-store unit and the data RAM. It tracks in-flight memory requests in a metadata pipeline matched to the LSU/RAM latency. It extracts and sign- or zero-extends the addressed byte, halfword or word from the returned 32-bit RAM word, and drives the register-file write port. It also detects misaligned accesses and flags them to the control path.

## Interface
Parameters:
- DATA_WIDTH, 32, data/address width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk_i  in  1  core clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  memory request issued to LSU this cycle
- req_ctrl_i  in  4  bit3 = write, bits2:0 = funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr_i  in  DATA_WIDTH  effective address of request
- req_regdest_i  in  REG_ADDR_WIDTH  load destination register
- flush_i  in  1  kill all in-flight requests
- mem_rdata_i  in  DATA_WIDTH  word returned by RAM, valid 2 cycles after request
- rf_wdata_o  out  DATA_WIDTH  extended load data
- rf_waddr_o  out  REG_ADDR_WIDTH  destination register
- rf_we_o  out  1  register-file write strobe
- misaligned_o  out  1  one-cycle misalignment pulse
- misaligned_addr_o  out  DATA_WIDTH  address of last misaligned request (held)
- busy_o  out  1  any load in flight

## Operation
- Metadata pipeline is two stages: S1 and S2. Each stage holds valid, is_load, funct3, addr[1:0] and regdest. A request accepted in cycle N occupies S1 in N+1 and S2 in N+2.
- Entry into S1 requires req_valid_i=1, req_ctrl_i[3]=0 (a load), a legal funct3, and the request being aligned.
- Stores and illegal funct3 codes (011, 110, 111) never enter the pipeline and produce no writeback. Stores are checked for misalignment only.
- Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]≠00. Applies to both loads and stores.
- On a misaligned request:
  - misaligned_o=1 in N+1.
  - misaligned_addr_o is loaded with req_addr_i at the same edge.
  - No writeback occurs.
- Extraction in S2 uses mem_rdata_i, little-endian:
  - B/BU: byte addr[1:0], bits [8k+7:8k].
  - H/HU: addr[1]=0 selects bits 15:0; addr[1]=1 selects bits 31:16.
  - W: full word.
  - B and H sign-extend; BU and HU zero-extend.
- Output register loads at the end of S2:
  - rf_wdata_o = extracted value.
  - rf_waddr_o = regdest.
  - rf_we_o = S2.valid && regdest≠0.
- busy_o = S1.valid | S2.valid | rf_we_o.
- flush_i=1 clears S1.valid, S2.valid and the pending rf_we_o at the next edge. A request presented in the same cycle as flush_i is dropped, but its misalignment is still reported.

## Timing
- Load latency is 3: request in N, then rf_we_o=1 during N+3 for exactly one cycle.
- Throughput is one load per cycle; back-to-back loads produce writebacks in consecutive cycles with no bubbles.
- mem_rdata_i is sampled only at the edge ending cycle N+2. It is ignored at other times.
- misaligned_o asserts in N+1 for one cycle per misaligned request. Consecutive misaligned requests give consecutive pulses, and misaligned_addr_o tracks the newest.
- Async reset, at any time including mid-load:
  - Outputs: rf_wdata_o=0, rf_waddr_o=0, rf_we_o=0, misaligned_o=0, misaligned_addr_o=0, busy_o=0.
  - All pipeline valids are cleared, and in-flight loads are discarded.
  - Operation resumes on the first edge after rst_i deasserts.
- Simultaneous flush_i and a writeback-to-be (S2 valid): the writeback is suppressed, so rf_we_o stays 0.
- rf_wdata_o and rf_waddr_o hold their last values when rf_we_o=0.

## Test plan
- LW, addr 0x100, rd=5, mem_rdata 0xDEADBEEF at N+2 -> N+3: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
- LB/LBU at addr low bits 0–3, rdata 0x80FF7F01 -> LB gives 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU byte 3 gives 0x00000080. LH at addr 2 gives 0xFFFF80FF; LHU at addr 2 gives 0x000080FF.
- Misaligned requests:
  - LW at 0x102 -> misaligned_o pulse in N+1, misaligned_addr_o=0x102, no rf_we_o.
  - SH at 0x203 -> pulse, misaligned_addr_o=0x203.
- Four back-to-back LW to rd 1–4 with distinct rdata -> rf_we_o high for four consecutive cycles N+3..N+6, with matching data and addresses.
- LW rd=0 -> rf_we_o stays 0. LW rd=7 followed by flush_i in N+1 -> no writeback, busy_o=0 by N+2.
- rst_i pulsed in N+1 during an LW -> all outputs 0 immediately; no writeback after release.
